mux_2x1: RTL and testbench
==========================

# mux_2x1

Two-input, word-wide selector used in the pipelined datapath wherever one of two 32-bit operands is chosen: PC source, ALU B operand, write-back data. The select path is purely combinational, so the output settles in the same cycle as the inputs. An optional registered copy of the output is provided for consumers that need a flopped value aligned to the clock.

## Interface
- WIDTH, default 32: data width of in0, in1, out and out_q.
- clk  input  1  single clock; used only by the registered output stage.
- rst_n  input  1  one clock; reset is asynchronous and active-low.
- in0  input  WIDTH  data returned when sel = 0.
- in1  input  WIDTH  data returned when sel = 1.
- sel  input  1  select; 0 picks in0, 1 picks in1.
- out  output  WIDTH  combinational selection result.
- out_q  output  WIDTH  registered selection result; see Configuration.

## Operation
- out = sel ? in1 : in0, bit for bit across all WIDTH bits.
- There is no enable and no hold.
- Unselected input changes never affect out.
- out is independent of clk and rst_n. Reset does not force out; it tracks the inputs even while rst_n = 0.
- When sel is X or Z in simulation, out follows the standard ternary merge: bits where in0 and in1 agree resolve, all other bits are X. No extra X-injection logic is added.
- out_q is captured from the same mux result as out. There is no separate select path.
- No internal state exists other than the out_q register.

## Timing
- out: zero-cycle latency. It is valid one propagation delay after any change on in0, in1 or sel. The bench samples 10 time units after stimulus.
- out_q with the register compiled in:
  - Captures out on every rising clk edge, so latency is 1 cycle.
  - Reset value is all zeros.
  - Asserting rst_n low clears out_q immediately, without waiting for a clock edge.
  - On release, the first rising edge with rst_n = 1 loads the current out.
- Reset asserted mid-stream discards the pending value. The next value after release is whatever the inputs present at that time.
- A sel toggle and a data change in the same cycle: out_q captures the combined result present at the edge.

## Configuration
- Macro: MUX_2X1_OUT_REG_EN.
- Defined:
  - out_q is a WIDTH-bit flop clocked by clk, with asynchronous active-low reset to 0.
  - Latency is 1 cycle, as described under Timing.
- Undefined:
  - No flop is generated.
  - out_q is a continuous assign of out, with zero latency.
  - clk and rst_n remain as ports but are unused.
- The port list is identical in both builds.

## Structure
- Package mux_2x1_pkg holds:
  - MUX_2X1_WIDTH = 32, the default for WIDTH.
  - Enum sel_e with SEL_IN0 = 1'b0 and SEL_IN1 = 1'b1, shared with the control unit for datapath select encodings.
- Sub-module mux_2x1_core contains the pure combinational WIDTH-generic selector. It is instantiated once.
- The top level adds the optional register stage and the macro guard.

## Test plan
- in0 = 0x12345678, in1 = 0xABCDEF01, sel = 0 -> out = 0x12345678.
- Same data, sel = 1 -> out = 0xABCDEF01.
- in0 = 0x00000000, in1 = 0xFFFFFFFF, sel = 0 -> out = 0x00000000; then sel = 1 -> out = 0xFFFFFFFF, with all bits toggling.
- rst_n = 0 with sel = 1 and in1 = 0xABCDEF01 -> out = 0xABCDEF01 immediately; out_q = 0 when the register is compiled in.
- With MUX_2X1_OUT_REG_EN:
  - Release reset, then change sel between edges -> out_q equals out sampled at the previous rising edge.
  - Drop rst_n asynchronously mid-cycle -> out_q = 0 with no clock edge.
- Without the macro: random in0, in1 and sel over 1000 vectors -> out_q == out and out == (sel ? in1 : in0) on every vector.

Source files
------------

// File: rtl/mux_2x1_pkg.sv
// Shared definitions for the 2:1 word selector and its users in the datapath
// control unit. Build option elsewhere: MUX_2X1_OUT_REG_EN.
package mux_2x1_pkg;

    // Default datapath word width
    localparam int MUX_2X1_WIDTH = 32;

    // Select encoding shared with the control unit (PC source, ALU B, write-back)
    typedef enum logic {
        SEL_IN0 = 1'b0,
        SEL_IN1 = 1'b1
    } sel_e;

endpackage : mux_2x1_pkg

// File: rtl/mux_2x1_core.sv
// Pure combinational WIDTH-generic 2:1 selector. A plain ternary is used so
// that an unknown select merges in0/in1 bit by bit in simulation.
module mux_2x1_core
    import mux_2x1_pkg::*;
#(
    parameter int WIDTH = MUX_2X1_WIDTH
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    // Per-bit selection; each bit is an independent 2:1 mux
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        assign out[gi] = (sel == SEL_IN1) ? in1[gi] : in0[gi];
    end

endmodule : mux_2x1_core

// File: rtl/mux_2x1.sv
// Top-level 2:1 word selector with an optional registered output copy.
// Define MUX_2X1_OUT_REG_EN to flop out_q (async active-low reset to zero);
// otherwise out_q is a wire copy of out and clk/rst_n are unused.
module mux_2x1
    import mux_2x1_pkg::*;
#(
    parameter int WIDTH = MUX_2X1_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q
);

    // Single selector instance feeds both the combinational and registered outputs
    mux_2x1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .in0 (in0),
        .in1 (in1),
        .sel (sel),
        .out (out)
    );

`ifdef MUX_2X1_OUT_REG_EN
    logic [WIDTH-1:0] out_d;

    // Next value of the output register is simply the current mux result
    always_comb begin
        out_d = out;
    end

    // Output register; reset clears it immediately, independent of clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end
`else
    // Zero-latency build: out_q mirrors out; clk and rst_n are kept as ports only
    assign out_q = out;

    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst_n};
`endif

endmodule : mux_2x1

// File: tb/tb_mux_2x1.sv
// Self-checking bench for mux_2x1. Works in both builds; register-specific
// scenarios are enabled when MUX_2X1_OUT_REG_EN is defined.
module tb_mux_2x1;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in0;
    logic [W-1:0] in1;
    logic         sel;
    logic [W-1:0] out;
    logic [W-1:0] out_q;

    int checks = 0;
    int errors = 0;

    mux_2x1 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in0   (in0),
        .in1   (in1),
        .sel   (sel),
        .out   (out),
        .out_q (out_q)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Reference: choose the operand indexed by the select value
    function automatic logic [W-1:0] model_mux(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic s);
        logic [W-1:0] operands [2];
        operands[0] = a;
        operands[1] = b;
        return operands[s];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        sel   = 1'b1;
        in0   = 32'h0;
        in1   = 32'hABCDEF01;
        #10;
        checks++;
        if (out !== 32'hABCDEF01) begin
            errors++;
            $display("FAIL reset_out got %h want %h", out, 32'hABCDEF01);
        end
        checks++;
`ifdef MUX_2X1_OUT_REG_EN
        if (out_q !== 32'h0) begin
            errors++;
            $display("FAIL reset_out_q got %h want %h", out_q, 32'h0);
        end
`else
        if (out_q !== 32'hABCDEF01) begin
            errors++;
            $display("FAIL reset_out_q got %h want %h", out_q, 32'hABCDEF01);
        end
`endif
        $display("reset: sel=%b in1=%h out=%h out_q=%h", sel, in1, out, out_q);
    endtask

    task automatic test_directed();
        logic [W-1:0] v0 [5];
        logic [W-1:0] v1 [5];
        logic         vs [5];
        logic [W-1:0] want [5];
        v0[0] = 32'h12345678; v1[0] = 32'hABCDEF01; vs[0] = 1'b0; want[0] = 32'h12345678;
        v0[1] = 32'h12345678; v1[1] = 32'hABCDEF01; vs[1] = 1'b1; want[1] = 32'hABCDEF01;
        v0[2] = 32'h00000000; v1[2] = 32'hFFFFFFFF; vs[2] = 1'b0; want[2] = 32'h00000000;
        v0[3] = 32'h00000000; v1[3] = 32'hFFFFFFFF; vs[3] = 1'b1; want[3] = 32'hFFFFFFFF;
        // unselected input changes while sel=1
        v0[4] = 32'h5A5A5A5A; v1[4] = 32'hFFFFFFFF; vs[4] = 1'b1; want[4] = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            in0 = v0[i];
            in1 = v1[i];
            sel = vs[i];
            #10;
            checks++;
            if (out !== want[i]) begin
                errors++;
                $display("FAIL directed_%0d got %h want %h", i, out, want[i]);
            end
            $display("directed %0d: in0=%h in1=%h sel=%b out=%h", i, in0, in1, sel, out);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] exp_out;
        logic [W-1:0] exp_q;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            in0 = $urandom;
            in1 = $urandom;
            sel = 1'($urandom_range(0, 1));
            exp_out = model_mux(in0, in1, sel);
            #10;
            checks++;
            if (out !== exp_out) begin
                errors++;
                $display("FAIL random_out[%0d] got %h want %h", i, out, exp_out);
            end
`ifdef MUX_2X1_OUT_REG_EN
            @(posedge clk);
            exp_q = model_mux(in0, in1, sel);
            #1;
            checks++;
            if (out_q !== exp_q) begin
                errors++;
                $display("FAIL random_out_q[%0d] got %h want %h", i, out_q, exp_q);
            end
`else
            exp_q = exp_out;
            checks++;
            if (out_q !== exp_q) begin
                errors++;
                $display("FAIL random_out_q[%0d] got %h want %h", i, out_q, exp_q);
            end
`endif
            $display("random %0d: in0=%h in1=%h sel=%b out=%h out_q=%h",
                     i, in0, in1, sel, out, out_q);
        end
    endtask

`ifdef MUX_2X1_OUT_REG_EN
    task automatic test_register();
        logic [W-1:0] exp_q;
        @(negedge clk);
        rst_n = 1'b1;
        in0 = 32'h11112222;
        in1 = 32'h33334444;
        sel = 1'b0;
        @(posedge clk);
        exp_q = 32'h11112222;
        #1;
        // change sel between edges: out_q must keep the previous-edge value
        sel = 1'b1;
        #5;
        checks++;
        if (out_q !== exp_q) begin
            errors++;
            $display("FAIL reg_hold got %h want %h", out_q, exp_q);
        end
        $display("register: sel toggled mid-cycle out=%h out_q=%h", out, out_q);
        // sel toggle plus data change in the same cycle
        @(negedge clk);
        sel = 1'b0;
        in0 = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        checks++;
        if (out_q !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL reg_combined got %h want %h", out_q, 32'hCAFEF00D);
        end
        $display("register: combined change out_q=%h", out_q);
    endtask

    task automatic test_async_reset();
        // mid-cycle reset assertion clears out_q without a clock edge
        #5;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_q !== 32'h0) begin
            errors++;
            $display("FAIL async_clear got %h want %h", out_q, 32'h0);
        end
        checks++;
        if (out !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL async_out got %h want %h", out, 32'hCAFEF00D);
        end
        $display("async reset: out=%h out_q=%h", out, out_q);
        // inputs change during reset; first edge after release loads them
        @(negedge clk);
        in1 = 32'h0BADBEEF;
        sel = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_q !== 32'h0) begin
            errors++;
            $display("FAIL held_in_reset got %h want %h", out_q, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_q !== 32'h0BADBEEF) begin
            errors++;
            $display("FAIL release_load got %h want %h", out_q, 32'h0BADBEEF);
        end
        $display("async reset release: out_q=%h", out_q);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
`ifdef MUX_2X1_OUT_REG_EN
        test_register();
        test_async_reset();
`else
        rst_n = 1'b1;
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mux_2x1
